display_scheduler: RTL and testbench



---
 rtl/display_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_display_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// Round-robin scheduler that time-shares the six-digit seven-segment driver between four
// value sources and a pre-empting alert. Optional macro BLANK_GAP_EN adds a blank gap per switch.
module display_scheduler #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES   = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic [3:0]  src_valid,
  input  logic [95:0] src_value,
  input  logic [3:0]  src_hex,
  input  logic        alert_req,
  input  logic [23:0] alert_value,
  output logic [23:0] disp_value,
  output logic        hex_mode,
  output logic [1:0]  src_sel,
  output logic        disp_active,
  output logic        disp_blank
);

  localparam int unsigned DwellW = $clog2(DWELL_CYCLES);
  localparam int unsigned GapW   = $clog2(GAP_CYCLES + 1);
  localparam int unsigned CntW0  = (DwellW > 26) ? DwellW : 26;
  localparam int unsigned CntW   = (GapW > CntW0) ? GapW : CntW0;
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);

`ifdef BLANK_GAP_EN
  localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {StIdle, StShow, StAlert, StGap} state_e;
  localparam state_e StSwitch = StGap;
`else
  typedef enum logic [1:0] {StIdle, StShow, StAlert} state_e;
  localparam state_e StSwitch = StShow;
`endif

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [1:0]      r_sel, w_sel_d;
  logic [1:0]      r_ptr, w_ptr_d;
  logic [23:0]     r_disp, w_disp_d;
  logic            r_hex, w_hex_d;
  logic            r_active, w_active_d;
  logic            r_blank, w_blank_d;
  logic [2:0]      w_next;
  logic [2:0]      w_first;
  logic [23:0]     w_vals [4];

  // {found, index} of the nearest valid source after cur; cur itself is checked last.
  function automatic logic [2:0] next_after(input logic [1:0] cur, input logic [3:0] valid);
    logic [2:0] res;
    logic [1:0] idx;
    res = {1'b0, cur};
    for (int i = 4; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (valid[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // {found, index} of the nearest valid source at or after ptr.
  function automatic logic [2:0] pick_from(input logic [1:0] ptr, input logic [3:0] valid);
    logic [2:0] res;
    logic [1:0] idx;
    res = {1'b0, ptr};
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (valid[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) w_vals[i] = src_value[24*i +: 24];
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_sel_d   = r_sel;
    w_ptr_d   = r_ptr;
    w_next    = next_after(r_sel, src_valid);
    w_first   = pick_from(r_ptr, src_valid);

    if (alert_req) begin
      // Counter and selection are held so the interrupted source resumes cleanly.
      w_state_d = StAlert;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_cnt_d = '0;
          if (w_first[2]) begin
            w_state_d = StShow;
            w_sel_d   = w_first[1:0];
          end
        end
        StShow: begin
          // A drop and an expiry on the same cycle collapse into one advance.
          if (!src_valid[r_sel] || (!pause && r_cnt == DwellLast)) begin
            w_cnt_d = '0;
            if (w_next[2]) begin
              w_state_d = StSwitch;
              w_sel_d   = w_next[1:0];
            end else begin
              w_state_d = StIdle;
            end
          end else if (!pause) begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        StAlert: begin
          w_cnt_d = '0;
          if (src_valid[r_sel]) begin
            w_state_d = StShow;
          end else if (w_next[2]) begin
            w_state_d = StShow;
            w_sel_d   = w_next[1:0];
          end else begin
            w_state_d = StIdle;
          end
        end
`ifdef BLANK_GAP_EN
        StGap: begin
          if (r_cnt == GapLast) begin
            w_cnt_d = '0;
            if (src_valid[r_sel]) begin
              w_state_d = StShow;
            end else if (w_next[2]) begin
              w_state_d = StShow;
              w_sel_d   = w_next[1:0];
            end else begin
              w_state_d = StIdle;
            end
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
`endif
        default: begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
      endcase
    end

    if (w_state_d == StShow) w_ptr_d = w_sel_d + 2'd1;
  end

  // Outputs are decoded from the next state so they register with one cycle of latency.
  always_comb begin
    w_disp_d   = '0;
    w_hex_d    = 1'b1;
    w_active_d = 1'b0;
    w_blank_d  = 1'b0;
    unique case (w_state_d)
      StShow: begin
        w_disp_d   = w_vals[w_sel_d];
        w_hex_d    = src_hex[w_sel_d];
        w_active_d = 1'b1;
      end
      StAlert: begin
        w_disp_d   = alert_value;
        w_active_d = 1'b1;
      end
`ifdef BLANK_GAP_EN
      StGap: begin
        w_blank_d = 1'b1;
      end
`endif
      default: begin
        w_disp_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_sel    <= 2'd0;
      r_ptr    <= 2'd0;
      r_disp   <= '0;
      r_hex    <= 1'b1;
      r_active <= 1'b0;
      r_blank  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_sel    <= w_sel_d;
      r_ptr    <= w_ptr_d;
      r_disp   <= w_disp_d;
      r_hex    <= w_hex_d;
      r_active <= w_active_d;
      r_blank  <= w_blank_d;
    end
  end

  assign disp_value  = r_disp;
  assign hex_mode    = r_hex;
  assign src_sel     = r_sel;
  assign disp_active = r_active;
  assign disp_blank  = r_blank;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with DWELL_CYCLES=8, GAP_CYCLES=3.
module tb_display_scheduler;

  logic        clk;
  logic        rst;
  logic        pause;
  logic [3:0]  src_valid;
  logic [95:0] src_value;
  logic [3:0]  src_hex;
  logic        alert_req;
  logic [23:0] alert_value;
  logic [23:0] disp_value;
  logic        hex_mode;
  logic [1:0]  src_sel;
  logic        disp_active;
  logic        disp_blank;

  int n_assert = 0;
  int n_fail   = 0;

  display_scheduler #(
    .DWELL_CYCLES(8),
    .GAP_CYCLES  (3)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .pause      (pause),
    .src_valid  (src_valid),
    .src_value  (src_value),
    .src_hex    (src_hex),
    .alert_req  (alert_req),
    .alert_value(alert_value),
    .disp_value (disp_value),
    .hex_mode   (hex_mode),
    .src_sel    (src_sel),
    .disp_active(disp_active),
    .disp_blank (disp_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".value"}, 32'(disp_value), 32'h0);
    chk({tag, ".hex"}, 32'(hex_mode), 32'h1);
    chk({tag, ".sel"}, 32'(src_sel), 32'h0);
    chk({tag, ".active"}, 32'(disp_active), 32'h0);
    chk({tag, ".blank"}, 32'(disp_blank), 32'h0);
  endtask

  // Leaves rst low at a falling edge with all inputs cleared.
  task automatic reset_dut();
    rst         = 1'b1;
    pause       = 1'b0;
    src_valid   = 4'b0000;
    src_value   = '0;
    src_hex     = 4'b0000;
    alert_req   = 1'b0;
    alert_value = 24'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset then sources 0 and 2 rotate.
    reset_dut();
    chk_reset_outputs("reset");
    src_value[23:0]  = 24'h111111;
    src_value[71:48] = 24'h333333;
    src_hex          = 4'b0100;
    src_valid        = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr.sel0", 32'(src_sel), 32'h0);
      chk("rr.val0", 32'(disp_value), 32'h111111);
      chk("rr.hex0", 32'(hex_mode), 32'h0);
      chk("rr.act0", 32'(disp_active), 32'h1);
      chk("rr.blank0", 32'(disp_blank), 32'h0);
    end
`ifdef BLANK_GAP_EN
    repeat (3) @(negedge clk);
`endif
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr.sel2", 32'(src_sel), 32'h2);
      chk("rr.val2", 32'(disp_value), 32'h333333);
      chk("rr.hex2", 32'(hex_mode), 32'h1);
    end
`ifdef BLANK_GAP_EN
    repeat (3) @(negedge clk);
`endif
    @(negedge clk);
    chk("rr.back0", 32'(src_sel), 32'h0);
    chk("rr.backval0", 32'(disp_value), 32'h111111);

    // Single source, value changes mid-dwell and is shown live.
    reset_dut();
    src_value[47:24] = 24'h222222;
    src_hex          = 4'b0010;
    src_valid        = 4'b0010;
    @(negedge clk);
    chk("live.sel", 32'(src_sel), 32'h1);
    chk("live.val", 32'(disp_value), 32'h222222);
    repeat (3) @(negedge clk);
    src_value[47:24] = 24'h00ABCD;
    chk("live.old", 32'(disp_value), 32'h222222);
    @(negedge clk);
    chk("live.new", 32'(disp_value), 32'h00ABCD);
    repeat (10) @(negedge clk);
    chk("live.stay", 32'(src_sel), 32'h1);

    // Alert pulse of five cycles at count 6 of source 0, then a fresh dwell.
    reset_dut();
    src_value[23:0]  = 24'h111111;
    src_value[47:24] = 24'h222222;
    alert_value      = 24'hA1E2F3;
    src_valid        = 4'b0011;
    repeat (7) @(negedge clk);
    chk("alert.pre", 32'(disp_value), 32'h111111);
    alert_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("alert.val", 32'(disp_value), 32'hA1E2F3);
      chk("alert.hex", 32'(hex_mode), 32'h1);
      chk("alert.sel", 32'(src_sel), 32'h0);
      chk("alert.act", 32'(disp_active), 32'h1);
    end
    alert_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("alert.resume.sel", 32'(src_sel), 32'h0);
      chk("alert.resume.val", 32'(disp_value), 32'h111111);
    end
    @(negedge clk);
    chk("alert.next", 32'(src_sel), 32'h1);

    // Current source drops while paused: advance, then idle when nothing is valid.
    reset_dut();
    src_value[71:48] = 24'h333333;
    src_value[95:72] = 24'h444444;
    src_valid        = 4'b1100;
    repeat (4) @(negedge clk);
    chk("drop.sel2", 32'(src_sel), 32'h2);
    pause     = 1'b1;
    src_valid = 4'b1000;
    @(negedge clk);
    chk("drop.sel3", 32'(src_sel), 32'h3);
`ifndef BLANK_GAP_EN
    chk("drop.val3", 32'(disp_value), 32'h444444);
`endif
    src_valid = 4'b0000;
    @(negedge clk);
`ifdef BLANK_GAP_EN
    repeat (2) @(negedge clk);
`endif
    chk("drop.idle.act", 32'(disp_active), 32'h0);
    chk("drop.idle.val", 32'(disp_value), 32'h0);
    chk("drop.idle.hex", 32'(hex_mode), 32'h1);
    pause = 1'b0;

    // Asynchronous reset mid-show takes effect before the next rising edge.
    reset_dut();
    src_value[47:24] = 24'h222222;
    src_valid        = 4'b0010;
    repeat (3) @(negedge clk);
    chk("arst.pre.sel", 32'(src_sel), 32'h1);
    chk("arst.pre.hex", 32'(hex_mode), 32'h0);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("arst");

`ifdef BLANK_GAP_EN
    // Blank gap between sources 0 and 1.
    reset_dut();
    src_value[23:0]  = 24'h111111;
    src_value[47:24] = 24'h222222;
    src_valid        = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("gap.src0", 32'(disp_value), 32'h111111);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gap.blank", 32'(disp_blank), 32'h1);
      chk("gap.val", 32'(disp_value), 32'h0);
      chk("gap.act", 32'(disp_active), 32'h0);
      chk("gap.sel", 32'(src_sel), 32'h1);
    end
    @(negedge clk);
    chk("gap.src1", 32'(disp_value), 32'h222222);
    chk("gap.unblank", 32'(disp_blank), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
